// File: rtl/raster_scheduler_pkg.sv
// Shared raster types: screen extent, vertex layout, scheduler states and
// the signed three-way min/max helpers used by the bounding-box stage.
package raster_scheduler_pkg;
  localparam int COORD_W         = 17;
  localparam int SCREEN_WIDTH    = 320;
  localparam int SCREEN_HEIGHT   = 180;
  localparam int CREDITS_DEFAULT = 64;

  typedef logic        [COORD_W-1:0] coord_t;
  typedef logic signed [COORD_W-1:0] scoord_t;
  // [0] = x, [1] = y
  typedef logic [1:0][COORD_W-1:0] vertex_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } raster_state_t;

  function automatic scoord_t smin3(input scoord_t a, input scoord_t b, input scoord_t c);
    scoord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic scoord_t smax3(input scoord_t a, input scoord_t b, input scoord_t c);
    scoord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/bbox_clamp.sv
// Registered screen-clamped bounding box of a triangle; loads on acceptance
// so the box is ready during the single SETUP cycle.
module bbox_clamp
  import raster_scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  vertex_t [2:0] vertices,
  output coord_t        xmin,
  output coord_t        xmax,
  output coord_t        ymin,
  output coord_t        ymax,
  output logic          empty
);
  localparam scoord_t ZERO    = '0;
  localparam scoord_t X_LIMIT = scoord_t'(SCREEN_WIDTH - 1);
  localparam scoord_t Y_LIMIT = scoord_t'(SCREEN_HEIGHT - 1);

  scoord_t lo_x, hi_x, lo_y, hi_y;
  logic    off_screen;

  always_comb begin
    lo_x = smin3($signed(vertices[0][0]), $signed(vertices[1][0]), $signed(vertices[2][0]));
    hi_x = smax3($signed(vertices[0][0]), $signed(vertices[1][0]), $signed(vertices[2][0]));
    lo_y = smin3($signed(vertices[0][1]), $signed(vertices[1][1]), $signed(vertices[2][1]));
    hi_y = smax3($signed(vertices[0][1]), $signed(vertices[1][1]), $signed(vertices[2][1]));
    if (lo_x < ZERO)    lo_x = ZERO;
    if (lo_y < ZERO)    lo_y = ZERO;
    if (hi_x > X_LIMIT) hi_x = X_LIMIT;
    if (hi_y > Y_LIMIT) hi_y = Y_LIMIT;
    // An inverted box after clamping means the triangle lies entirely off-screen.
    off_screen = (lo_x > hi_x) || (lo_y > hi_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin  <= '0;
      xmax  <= '0;
      ymin  <= '0;
      ymax  <= '0;
      empty <= 1'b0;
    end else if (load) begin
      xmin  <= $unsigned(lo_x);
      xmax  <= $unsigned(hi_x);
      ymin  <= $unsigned(lo_y);
      ymax  <= $unsigned(hi_y);
      empty <= off_screen;
    end
  end
endmodule

// File: rtl/raster_scheduler.sv
// Walks a triangle's clamped bounding box row-major, issuing one point per
// cycle to a non-stallable barycentric pipe, throttled by downstream credits.
module raster_scheduler
  import raster_scheduler_pkg::*;
#(
  parameter int CREDITS = CREDITS_DEFAULT
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  // A triangle transfers on a rising edge where tri_valid_in and tri_ready_out are both high.
  input  logic          tri_valid_in,
  output logic          tri_ready_out,
  input  vertex_t [2:0] vertices_in,
  output logic          bary_valid_out,
  output vertex_t       bary_point_out,
  output vertex_t [2:0] bary_vertices_out,
  input  logic          bary_result_valid_in,
  input  logic          credit_return_in,
  output logic          busy_out,
  output logic          done_out,
  output logic          error_out,
  output raster_state_t debug_state
);
  localparam int            CW          = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam coord_t        COORD_ONE   = coord_t'(1);

  raster_state_t state, state_next;
  logic [CW-1:0] credits, outstanding;
  coord_t        cur_x, cur_y;
  coord_t        box_xmin, box_xmax, box_ymin, box_ymax;
  logic          box_empty;
  logic          accept, issue, row_end, last_point;
  logic          credit_overflow, result_ok, result_orphan;

  assign accept          = (state == IDLE) && tri_valid_in;
  assign issue           = (state == SCAN) && (credits != '0);
  assign row_end         = (cur_x == box_xmax);
  assign last_point      = row_end && (cur_y == box_ymax);
  assign credit_overflow = credit_return_in && !issue && (credits == CREDITS_MAX);
  assign result_ok       = bary_result_valid_in && (outstanding != '0);
  assign result_orphan   = bary_result_valid_in && (outstanding == '0);

  assign tri_ready_out = (state == IDLE) && rst_n_in;
  assign busy_out      = (state != IDLE);
  assign debug_state   = state;

  bbox_clamp u_bbox (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .load     (accept),
    .vertices (vertices_in),
    .xmin     (box_xmin),
    .xmax     (box_xmax),
    .ymin     (box_ymin),
    .ymax     (box_ymax),
    .empty    (box_empty)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tri_valid_in) state_next = SETUP;
      SETUP:   state_next = box_empty ? DRAIN : SCAN;
      SCAN:    if (issue && last_point) state_next = DRAIN;
      DRAIN:   if (outstanding == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cur_x             <= '0;
      cur_y             <= '0;
      bary_valid_out    <= 1'b0;
      bary_point_out    <= '0;
      bary_vertices_out <= '0;
      done_out          <= 1'b0;
      error_out         <= 1'b0;
    end else begin
      bary_valid_out <= issue;
      done_out       <= (state == DRAIN) && (outstanding == '0);
      error_out      <= error_out | credit_overflow | result_orphan;
      if (accept) bary_vertices_out <= vertices_in;
      if (state == SETUP) begin
        cur_x <= box_xmin;
        cur_y <= box_ymin;
      end else if (issue) begin
        bary_point_out[0] <= cur_x;
        bary_point_out[1] <= cur_y;
        if (row_end) begin
          cur_x <= box_xmin;
          cur_y <= cur_y + COORD_ONE;
        end else begin
          cur_x <= cur_x + COORD_ONE;
        end
      end
    end
  end

  // Simultaneous issue/return (or issue/result) cancel; illegal events are dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      credits     <= CREDITS_MAX;
      outstanding <= '0;
    end else begin
      if (issue && !credit_return_in)
        credits <= credits - CNT_ONE;
      else if (!issue && credit_return_in && !credit_overflow)
        credits <= credits + CNT_ONE;
      if (issue && !result_ok)
        outstanding <= outstanding + CNT_ONE;
      else if (!issue && result_ok)
        outstanding <= outstanding - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_raster_scheduler.sv
// Randomized bench for raster_scheduler: a point-list model of each triangle,
// a modelled barycentric pipe and fragment FIFO, per-cycle handshake checks.
module tb_raster_scheduler;
  import raster_scheduler_pkg::*;

  localparam int CREDITS = 8;
  localparam int LAT     = 2;
  localparam int NO_EDGE = 32'h7fffffff;

  logic          clk_in;
  logic          rst_n_in;
  logic          tri_valid_in;
  logic          tri_ready_out;
  vertex_t [2:0] vertices_in;
  logic          bary_valid_out;
  vertex_t       bary_point_out;
  vertex_t [2:0] bary_vertices_out;
  logic          bary_result_valid_in;
  logic          credit_return_in;
  logic          busy_out;
  logic          done_out;
  logic          error_out;
  raster_state_t debug_state;

  raster_scheduler #(.CREDITS(CREDITS)) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .tri_valid_in         (tri_valid_in),
    .tri_ready_out        (tri_ready_out),
    .vertices_in          (vertices_in),
    .bary_valid_out       (bary_valid_out),
    .bary_point_out       (bary_point_out),
    .bary_vertices_out    (bary_vertices_out),
    .bary_result_valid_in (bary_result_valid_in),
    .credit_return_in     (credit_return_in),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .error_out            (error_out),
    .debug_state          (debug_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- scoreboard state ----------------
  logic [33:0]   exp_q[$];     // {y, x} in expected issue order
  int            res_due[$];   // edge at which each pipe result must appear
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cycle    = 0;
  int            scan_from = NO_EDGE;
  int            done_at   = NO_EDGE;
  int            exp_total = 0;
  int            results_got = 0;
  int            held = 0;       // credits currently away from the scheduler
  int            fifo_level = 0;
  int            done_count = 0;
  int            pop_pct = 100;
  bit            pop_en = 1'b1;
  bit            req_one_pop = 1'b0;
  bit            req_extra_ret = 1'b0;
  bit            req_stray_res = 1'b0;
  bit            ret_normal = 1'b0;
  bit            res_stray = 1'b0;
  bit            exp_err = 1'b0;
  bit            tri_active = 1'b0;
  bit            prev_ready = 1'b0;
  bit            exp_valid, exp_done;
  vertex_t [2:0] cur_vertices;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  // ---------------- monitor, pipe and FIFO model ----------------
  initial begin : monitor
    bary_result_valid_in = 1'b0;
    credit_return_in     = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      cycle++;
      if (!rst_n_in) begin
        exp_q.delete();
        res_due.delete();
        fifo_level = 0;
        held = 0;
        results_got = 0;
        scan_from = NO_EDGE;
        done_at = NO_EDGE;
        tri_active = 1'b0;
        exp_err = 1'b0;
        bary_result_valid_in = 1'b0;
        credit_return_in = 1'b0;
        ret_normal = 1'b0;
        res_stray = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (tri_valid_in && prev_ready) begin
          tri_active   = 1'b1;
          results_got  = 0;
          cur_vertices = vertices_in;
          scan_from    = cycle + 2;
          done_at      = (exp_total == 0) ? cycle + 2 : NO_EDGE;
        end
        exp_valid = (cycle >= scan_from) && (exp_q.size() > 0) && (held < CREDITS);
        check_eq("issue_valid", bary_valid_out, exp_valid);
        if (bary_valid_out) begin
          if (exp_q.size() > 0)
            check_eq("issue_point", {bary_point_out[1], bary_point_out[0]}, exp_q.pop_front());
          check_eq("issue_vertices", bary_vertices_out, cur_vertices);
          held++;
          res_due.push_back(cycle + LAT);
        end
        if (credit_return_in) begin
          if (ret_normal) held--;
          else            exp_err = 1'b1;
        end
        if (bary_result_valid_in) begin
          if (res_stray) exp_err = 1'b1;
          else begin
            results_got++;
            if (results_got == exp_total) done_at = cycle + 1;
          end
        end
        exp_done = (cycle == done_at);
        check_eq("done_pulse", done_out, exp_done);
        if (done_out) done_count++;
        if (exp_done) begin
          tri_active = 1'b0;
          done_at    = NO_EDGE;
          scan_from  = NO_EDGE;
        end
        check_eq("busy", busy_out, tri_active);
        check_eq("tri_ready", tri_ready_out, !tri_active);
        check_eq("error", error_out, exp_err);

        bary_result_valid_in = 1'b0;
        credit_return_in     = 1'b0;
        ret_normal           = 1'b0;
        res_stray            = 1'b0;
        if (fifo_level > 0 && ((pop_en && int'($urandom_range(0, 99)) < pop_pct) || req_one_pop)) begin
          credit_return_in = 1'b1;
          ret_normal       = 1'b1;
          fifo_level--;
          req_one_pop      = 1'b0;
        end else if (req_extra_ret) begin
          credit_return_in = 1'b1;
          req_extra_ret    = 1'b0;
        end
        if (res_due.size() > 0 && res_due[0] == cycle + 1) begin
          void'(res_due.pop_front());
          bary_result_valid_in = 1'b1;
          fifo_level++;
        end else if (req_stray_res) begin
          bary_result_valid_in = 1'b1;
          res_stray            = 1'b1;
          req_stray_res        = 1'b0;
        end
        prev_ready = tri_ready_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2);
    int lx, hx, ly, hy;
    lx = imax(imin(imin(x0, x1), x2), 0);
    hx = imin(imax(imax(x0, x1), x2), SCREEN_WIDTH - 1);
    ly = imax(imin(imin(y0, y1), y2), 0);
    hy = imin(imax(imax(y0, y1), y2), SCREEN_HEIGHT - 1);
    exp_total = 0;
    for (int y = ly; y <= hy; y++) begin
      for (int x = lx; x <= hx; x++) begin
        exp_q.push_back({17'(y), 17'(x)});
        exp_total++;
      end
    end
    @(negedge clk_in);
    vertices_in[0][0] = 17'(x0);
    vertices_in[0][1] = 17'(y0);
    vertices_in[1][0] = 17'(x1);
    vertices_in[1][1] = 17'(y1);
    vertices_in[2][0] = 17'(x2);
    vertices_in[2][1] = 17'(y2);
    tri_valid_in = 1'b1;
    @(negedge clk_in);
    tri_valid_in = 1'b0;
    for (int v = 0; v < 3; v++) begin
      vertices_in[v][0] = 17'($urandom);
      vertices_in[v][1] = 17'($urandom);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    start = done_count;
    for (int i = 0; i < budget && done_count == start; i++) @(negedge clk_in);
    check_eq(tag, done_count - start, 1);
    check_eq({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic run_tri(input string tag, input int x0, input int y0, input int x1,
                         input int y1, input int x2, input int y2, input int budget);
    send_tri(x0, y0, x1, y1, x2, y2);
    wait_done(tag, budget);
  endtask

  task automatic settle();
    for (int i = 0; i < 200 && (fifo_level > 0 || res_due.size() > 0); i++) @(negedge clk_in);
    check_eq("settle_held", held, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    rst_n_in     = 1'b0;
    tri_valid_in = 1'b0;
    vertices_in  = '0;
    #12;
    check_eq("rst_ready", tri_ready_out, 1'b0);
    check_eq("rst_busy", busy_out, 1'b0);
    check_eq("rst_valid", bary_valid_out, 1'b0);
    check_eq("rst_point", bary_point_out, 0);
    check_eq("rst_done", done_out, 1'b0);
    check_eq("rst_error", error_out, 1'b0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check_eq("ready_after_rst", tri_ready_out, 1'b1);

    run_tri("small_tri", 0, 0, 2, 0, 0, 2, 200);

    settle();
    pop_en = 1'b0;
    send_tri(0, 0, 15, 0, 0, 0);
    repeat (30) @(negedge clk_in);
    check_eq("starved_left", exp_q.size(), 16 - CREDITS);
    req_one_pop = 1'b1;
    repeat (5) @(negedge clk_in);
    check_eq("one_credit_left", exp_q.size(), 16 - CREDITS - 1);
    pop_en  = 1'b1;
    pop_pct = 100;
    wait_done("starved_done", 300);

    for (int t = 0; t < 12; t++) begin
      int bx, by;
      pop_pct = rnd(30, 100);
      bx = rnd(-40, 360);
      by = rnd(-30, 210);
      run_tri("rand_tri", bx + rnd(-10, 10), by + rnd(-10, 10), bx + rnd(-10, 10),
              by + rnd(-10, 10), bx + rnd(-10, 10), by + rnd(-10, 10), 4000);
    end

    pop_pct = 100;
    run_tri("offscreen_x", 320, 0, 400, 50, 330, 100, 50);
    run_tri("offscreen_neg", -30, 10, -5, 20, -9, 40, 50);
    run_tri("full_screen", -5, -5, 400, 10, 10, 300, 70000);

    settle();
    req_extra_ret = 1'b1;
    repeat (3) @(negedge clk_in);
    check_eq("overflow_error", error_out, 1'b1);
    run_tri("after_error", 1, 1, 3, 2, 2, 4, 200);
    check_eq("error_sticky", error_out, 1'b1);

    send_tri(0, 0, 100, 0, 0, 20);
    repeat (20) @(negedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("abort_valid", bary_valid_out, 1'b0);
    check_eq("abort_point", bary_point_out, 0);
    check_eq("abort_vertices", bary_vertices_out, 0);
    check_eq("abort_busy", busy_out, 1'b0);
    check_eq("abort_error", error_out, 1'b0);
    check_eq("abort_ready", tri_ready_out, 1'b0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check_eq("rel_ready", tri_ready_out, 1'b1);
    check_eq("rel_error", error_out, 1'b0);
    req_stray_res = 1'b1;
    repeat (3) @(negedge clk_in);
    check_eq("stray_error", error_out, 1'b1);
    run_tri("after_abort", 5, 5, 8, 5, 5, 7, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
